data_arith_extend_pipe: RTL and testbench

DATA_ARITH_EXTEND_PIPE -- requirements
Module: data_arith_extend_pipe

---
 rtl/data_arith_extend_pipe_if.sv | 25 ++
 rtl/data_arith_extend_pipe.sv | 83 ++++++++
 tb/tb_data_arith_extend_pipe.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/data_arith_extend_pipe_if.sv
// Handshake bundle for data_arith_extend_pipe: packed input lanes with per-lane
// extend mode on the upstream side, packed result lanes on the downstream side.
interface data_arith_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
);
    logic [DEPTH*IN_W-1:0]  in;
    logic [DEPTH-1:0]       in_sign;
    logic                   in_valid;
    logic                   in_ready;
    logic [DEPTH*OUT_W-1:0] out;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in, in_sign, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  in, in_sign, in_valid, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/data_arith_extend_pipe.sv
// Elastic pipeline that sign/zero-extends (or truncates) each input lane to OUT_W
// on entry, then carries the results through STAGES valid/ready register slots.
module data_arith_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 2,
    parameter int STAGES = 2
) (
    input logic                     clk,
    input logic                     rst,
    data_arith_extend_pipe_if.slave bus
);
    localparam int LW = DEPTH * OUT_W;

    logic [LW-1:0]     ext_data;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic [LW-1:0]     data_q [STAGES];
    logic [LW-1:0]     data_d [STAGES];
    logic              slot0_room;
    logic              accept;

    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        if (OUT_W > IN_W) begin : g_ext
            assign ext_data[i*OUT_W +: OUT_W] =
                {{(OUT_W-IN_W){bus.in_sign[i] & bus.in[i*IN_W+IN_W-1]}}, bus.in[i*IN_W +: IN_W]};
        end else if (OUT_W == IN_W) begin : g_copy
            logic unused_sign;
            assign unused_sign = bus.in_sign[i];
            assign ext_data[i*OUT_W +: OUT_W] = bus.in[i*IN_W +: IN_W];
        end else begin : g_trunc
            // Truncation ignores the mode bit and the dropped upper bits.
            logic unused_bits;
            assign unused_bits = ^{bus.in_sign[i], bus.in[i*IN_W+OUT_W +: IN_W-OUT_W]};
            assign ext_data[i*OUT_W +: OUT_W] = bus.in[i*IN_W +: OUT_W];
        end
    end

    // Walk from the output back: a slot moves when the slot ahead has room this edge.
    always_comb begin
        logic room;
        room = bus.out_ready;
        adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = valid_q[k] & room;
            room   = ~valid_q[k] | adv[k];
        end
        slot0_room = room;
    end

    always_comb begin
        accept = bus.in_valid & slot0_room;
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k] & ~adv[k];
            data_d[k]  = data_q[k];
        end
        if (accept) begin
            valid_d[0] = 1'b1;
            data_d[0]  = ext_data;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = data_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
        end
    end

    assign bus.in_ready  = slot0_room;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out       = data_q[STAGES-1];
endmodule

// File: tb/tb_data_arith_extend_pipe.sv
// Bench for data_arith_extend_pipe: directed handshake scenarios plus a randomized
// phase, checked against a FIFO reference model of arithmetic lane extension.
module tb_data_arith_extend_pipe;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 32;
    localparam int DEPTH  = 2;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_arith_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();
    data_arith_extend_pipe_if #(.IN_W(8), .OUT_W(4), .DEPTH(1)) bn ();
    data_arith_extend_pipe_if #(.IN_W(8), .OUT_W(8), .DEPTH(1)) be ();

    data_arith_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .STAGES(STAGES))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));
    data_arith_extend_pipe #(.IN_W(8), .OUT_W(4), .DEPTH(1), .STAGES(1))
        dut_narrow (.clk(clk), .rst(rst), .bus(bn.slave));
    data_arith_extend_pipe #(.IN_W(8), .OUT_W(8), .DEPTH(1), .STAGES(1))
        dut_equal (.clk(clk), .rst(rst), .bus(be.slave));

    int checks = 0;
    int errors = 0;

    logic [DEPTH*OUT_W-1:0] q[$];
    logic                   hold = 1'b0;
    logic [DEPTH*OUT_W-1:0] held_out;
    logic                   last_acc, last_drn, last_ov;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each lane read as an unsigned or two's-complement number, then reduced mod 2**OUT_W.
    function automatic logic [DEPTH*OUT_W-1:0] ref_ext(input logic [DEPTH*IN_W-1:0] d,
                                                       input logic [DEPTH-1:0] s);
        logic [DEPTH*OUT_W-1:0] res;
        longint v;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = longint'(d[i*IN_W +: IN_W]);
            if (s[i] && v >= (longint'(1) << (IN_W - 1))) v = v - (longint'(1) << IN_W);
            res[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
        return res;
    endfunction

    task automatic step(input logic v, input logic [DEPTH*IN_W-1:0] d,
                        input logic [DEPTH-1:0] s, input logic ordy);
        bus.in        = d;
        bus.in_sign   = s;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", bus.in_ready, !(q.size() == STAGES && !ordy));
        if (q.size() == STAGES) chk("full_out_valid", bus.out_valid, 1'b1);
        if (hold) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_data", bus.out, held_out);
        end
        if (bus.out_valid) begin
            if (q.size() == 0) chk("out_valid_model_empty", bus.out_valid, 1'b0);
            else               chk("out_data", bus.out, q[0]);
        end
        last_ov  = bus.out_valid;
        last_acc = v && bus.in_ready;
        last_drn = bus.out_valid && ordy;
        hold     = bus.out_valid && !ordy;
        held_out = bus.out;
        @(posedge clk);
        if (last_drn && q.size() > 0) void'(q.pop_front());
        if (last_acc) q.push_back(ref_ext(d, s));
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            step(1'b0, '0, '0, 1'b1);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int acc_cnt, run, n;
        rst = 1'b1;
        bus.in = '0; bus.in_sign = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bn.in = '0; bn.in_sign = '0; bn.in_valid = 1'b0; bn.out_ready = 1'b1;
        be.in = '0; be.in_sign = '0; be.in_valid = 1'b0; be.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out", bus.out, '0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Known-answer transaction and its latency
        step(1'b1, {16'h8001, 16'h8001}, 2'b01, 1'b1);
        chk("lat_not_early", bus.out_valid, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("kat_valid", bus.out_valid, 1'b1);
        chk("kat_data", bus.out, 64'h00008001_FFFF8001);
        step(1'b0, '0, '0, 1'b1);
        chk("kat_one_cycle", bus.out_valid, 1'b0);

        // Ten back-to-back transactions
        run = 0;
        for (int i = 0; i < 10 + STAGES + 2; i++) begin
            step(i < 10, $urandom, 2'($urandom), 1'b1);
            if (i < 10) chk("stream_accept", last_acc, 1'b1);
            if (last_ov) run++;
        end
        chk("stream_out_cycles", run, 10);
        chk("stream_empty", q.size(), 0);

        // Back-pressure until full
        acc_cnt = 0; n = 0;
        do begin
            step(1'b1, $urandom, 2'($urandom), 1'b0);
            if (last_acc) acc_cnt++;
            n++;
        end while (last_acc && n < 20);
        chk("full_accepts", acc_cnt, STAGES);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 2'($urandom), 1'b0);
        drain();

        // Full pipeline with simultaneous accept and drain
        for (int i = 0; i < STAGES; i++) step(1'b1, $urandom, 2'($urandom), 1'b0);
        step(1'b1, $urandom, 2'($urandom), 1'b1);
        chk("sim_accept", last_acc, 1'b1);
        chk("sim_drain", last_drn, 1'b1);
        chk("sim_occupancy", q.size(), STAGES);
        drain();

        // Asynchronous reset with items in flight; no transfer while held
        step(1'b1, $urandom, 2'($urandom), 1'b0);
        step(1'b1, $urandom, 2'($urandom), 1'b0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_out", bus.out, '0);
        chk("arst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("arst_no_transfer", bus.out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        hold = 1'b0;
        step(1'b1, {16'h7FFF, 16'hFFFF}, 2'b11, 1'b1);
        chk("post_rst_not_early", bus.out_valid, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("post_rst_valid", bus.out_valid, 1'b1);
        chk("post_rst_data", bus.out, 64'h00007FFF_FFFFFFFF);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), $urandom, 2'($urandom), $urandom_range(0, 9) < 7);
        drain();

        // Narrowing and equal-width lanes
        bn.in = 8'hA7; bn.in_sign = 1'b1; bn.in_valid = 1'b1;
        be.in = 8'hA7; be.in_sign = 1'b1; be.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("narrow_valid", bn.out_valid, 1'b1);
        chk("narrow_sign1", bn.out, 4'h7);
        chk("equal_sign1", be.out, 8'hA7);
        @(negedge clk);
        bn.in_sign = 1'b0;
        be.in_sign = 1'b0;
        @(posedge clk);
        #1;
        chk("narrow_sign0", bn.out, 4'h7);
        chk("equal_sign0", be.out, 8'hA7);
        @(negedge clk);
        bn.in_valid = 1'b0;
        be.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
